// File: rtl/mem_port_arbiter.sv
// Single-port 64-bit memory arbiter for the boot loader, CPU data port and CPU fetch.
// One transaction in flight; fixed priority loader > data > fetch with a fetch anti-starvation guard.
module mem_port_arbiter #(
  parameter int AW         = 8,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_req,
  input  logic [AW:0]   ld_addr,
  input  logic [31:0]   ld_wdata,
  output logic          ld_gnt,
  input  logic          d_req,
  input  logic [1:0]    d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [63:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [63:0]   d_rdata,
  input  logic          i_req,
  input  logic [AW:0]   i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [31:0]   i_rdata,
  output logic          mem_en,
  output logic [1:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [63:0]   mem_wdata,
  input  logic [63:0]   mem_rdata,
  output logic          busy
);

  // state   | meaning
  // IDLE    | arbitrate among pending requests; read responses are presented here
  // ACCESS  | memory strobe and grant for the latched winner
  // RD_WAIT | waiting out the remaining memory read latency
  // RESP    | mem_rdata valid, captured at the end of the cycle
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACCESS  = 2'd1;
  localparam logic [1:0] S_RD_WAIT = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

  localparam logic [1:0] OWN_LD = 2'd0;
  localparam logic [1:0] OWN_D  = 2'd1;
  localparam logic [1:0] OWN_I  = 2'd2;

  localparam int              LW         = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;
  localparam logic [LW-1:0]   WAIT_INIT  = LW'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);
  localparam int              SW         = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [SW-1:0]   STARVE_TOP = SW'(STARVE_MAX);

  logic [1:0]    state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  logic          half_q, half_d;
  logic [LW-1:0] wait_q, wait_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          ld_gnt_q, ld_gnt_d;
  logic          d_gnt_q, d_gnt_d;
  logic          i_gnt_q, i_gnt_d;
  logic          d_rvalid_q, d_rvalid_d;
  logic          i_rvalid_q, i_rvalid_d;
  logic [63:0]   d_rdata_q, d_rdata_d;
  logic [31:0]   i_rdata_q, i_rdata_d;
  logic          mem_en_q, mem_en_d;
  logic [1:0]    mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [63:0]   mem_wdata_q, mem_wdata_d;
  logic          fetch_first;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    half_d      = half_q;
    wait_d      = wait_q;
    starve_d    = starve_q;
    ld_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    i_gnt_d     = 1'b0;
    d_rvalid_d  = 1'b0;
    i_rvalid_d  = 1'b0;
    d_rdata_d   = d_rdata_q;
    i_rdata_d   = i_rdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 2'b00;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    fetch_first = i_req && (starve_q == STARVE_TOP);

    case (state_q)
      S_IDLE: begin
        if (ld_req || d_req || i_req) begin
          state_d  = S_ACCESS;
          mem_en_d = 1'b1;
          if (ld_req) begin
            owner_d     = OWN_LD;
            ld_gnt_d    = 1'b1;
            mem_we_d    = ld_addr[0] ? 2'b10 : 2'b01;
            mem_addr_d  = ld_addr[AW:1];
            mem_wdata_d = {ld_wdata, ld_wdata};
          end else if (d_req && !fetch_first) begin
            owner_d     = OWN_D;
            d_gnt_d     = 1'b1;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
          end else begin
            owner_d    = OWN_I;
            i_gnt_d    = 1'b1;
            half_d     = i_addr[0];
            mem_addr_d = i_addr[AW:1];
          end
          if (i_req) begin
            if (i_gnt_d)
              starve_d = '0;
            else if (starve_q != STARVE_TOP)
              starve_d = starve_q + 1'b1;
          end
        end
      end
      S_ACCESS: begin
        // Only reads carry an all-zero write enable, so the strobe tells us the direction.
        if (mem_we_q != 2'b00) begin
          state_d = S_IDLE;
        end else if (MEM_LAT > 1) begin
          state_d = S_RD_WAIT;
          wait_d  = WAIT_INIT;
        end else begin
          state_d = S_RESP;
        end
      end
      S_RD_WAIT: begin
        if (wait_q == '0)
          state_d = S_RESP;
        else
          wait_d = wait_q - 1'b1;
      end
      S_RESP: begin
        state_d = S_IDLE;
        if (owner_q == OWN_I) begin
          i_rvalid_d = 1'b1;
          i_rdata_d  = half_q ? mem_rdata[63:32] : mem_rdata[31:0];
        end else begin
          d_rvalid_d = 1'b1;
          d_rdata_d  = mem_rdata;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (!i_req)
      starve_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_LD;
      half_q      <= 1'b0;
      wait_q      <= '0;
      starve_q    <= '0;
      ld_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      i_gnt_q     <= 1'b0;
      d_rvalid_q  <= 1'b0;
      i_rvalid_q  <= 1'b0;
      d_rdata_q   <= '0;
      i_rdata_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 2'b00;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      half_q      <= half_d;
      wait_q      <= wait_d;
      starve_q    <= starve_d;
      ld_gnt_q    <= ld_gnt_d;
      d_gnt_q     <= d_gnt_d;
      i_gnt_q     <= i_gnt_d;
      d_rvalid_q  <= d_rvalid_d;
      i_rvalid_q  <= i_rvalid_d;
      d_rdata_q   <= d_rdata_d;
      i_rdata_q   <= i_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign ld_gnt    = ld_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign i_gnt     = i_gnt_q;
  assign d_rvalid  = d_rvalid_q;
  assign i_rvalid  = i_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign i_rdata   = i_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: memory model, transaction-level reference model with a
// per-cycle compare, directed scenarios with literal expectations and a randomized run.
module tb_mem_port_arbiter;
  localparam int AW         = 8;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ld_req, ld_gnt;
  logic [AW:0]   ld_addr;
  logic [31:0]   ld_wdata;
  logic          d_req, d_gnt, d_rvalid;
  logic [1:0]    d_we;
  logic [AW-1:0] d_addr;
  logic [63:0]   d_wdata, d_rdata;
  logic          i_req, i_gnt, i_rvalid;
  logic [AW:0]   i_addr;
  logic [31:0]   i_rdata;
  logic          mem_en, busy;
  logic [1:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [63:0]   mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Memory array: read data appears MEM_LAT cycles after the strobe, garbage otherwise.
  logic [63:0] sim_mem [0:255];
  logic [63:0] rd_pipe [0:MEM_LAT-1];
  logic        rd_v    [0:MEM_LAT-1] = '{default: 1'b0};
  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr = 8'd0;
  logic [63:0] pl_data = 64'd0;

  always @(posedge clk) begin
    for (int k = MEM_LAT - 1; k > 0; k--) begin
      rd_pipe[k] <= rd_pipe[k-1];
      rd_v[k]    <= rd_v[k-1];
    end
    rd_pipe[0] <= sim_mem[mem_addr];
    rd_v[0]    <= mem_en && (mem_we == 2'b00);
    if (mem_en && mem_we[0]) sim_mem[mem_addr][31:0]  <= mem_wdata[31:0];
    if (mem_en && mem_we[1]) sim_mem[mem_addr][63:32] <= mem_wdata[63:32];
    if (pl_en) sim_mem[pl_addr] <= pl_data;
  end

  assign mem_rdata = rd_v[MEM_LAT-1] ? rd_pipe[MEM_LAT-1] : 64'hBAD0_BAD0_BAD0_BAD0;

  // Reference model: tracks how long the port stays occupied and when a response is due.
  logic [63:0] ref_mem [0:255];
  logic        e_ld_gnt, e_d_gnt, e_i_gnt, e_mem_en, e_busy, e_d_rv, e_i_rv;
  logic [1:0]  e_mem_we;
  logic [7:0]  e_mem_addr;
  logic [63:0] e_mem_wdata, e_d_rdata;
  logic [31:0] e_i_rdata;
  int          m_wait, m_rv_in, m_starve, m_rv_who, who;
  logic [63:0] m_rv_word;
  logic        m_rv_half, prev_idle;

  always @(posedge clk or negedge reset) begin
    if (pl_en) ref_mem[pl_addr] = pl_data;
    if (!reset) begin
      e_ld_gnt = 0; e_d_gnt = 0; e_i_gnt = 0; e_mem_en = 0; e_busy = 0; e_d_rv = 0; e_i_rv = 0;
      e_mem_we = 0; e_mem_addr = 0; e_mem_wdata = 0; e_d_rdata = 0; e_i_rdata = 0;
      m_wait = 0; m_rv_in = 0; m_starve = 0;
    end else begin
      prev_idle = (m_wait == 0);
      e_ld_gnt = 0; e_d_gnt = 0; e_i_gnt = 0; e_mem_en = 0; e_mem_we = 0; e_d_rv = 0; e_i_rv = 0;
      if (m_wait > 0) m_wait--;
      if (m_rv_in > 0) begin
        m_rv_in--;
        if (m_rv_in == 0) begin
          if (m_rv_who == 2) begin
            e_d_rv = 1; e_d_rdata = m_rv_word;
          end else begin
            e_i_rv = 1; e_i_rdata = m_rv_half ? m_rv_word[63:32] : m_rv_word[31:0];
          end
        end
      end
      if (prev_idle && (ld_req || d_req || i_req)) begin
        if (ld_req) who = 1;
        else if (d_req && !(i_req && m_starve >= STARVE_MAX)) who = 2;
        else who = 3;
        e_mem_en = 1;
        case (who)
          1: begin
            e_ld_gnt = 1; e_mem_we = ld_addr[0] ? 2'b10 : 2'b01;
            e_mem_addr = ld_addr[8:1]; e_mem_wdata = {ld_wdata, ld_wdata};
          end
          2: begin
            e_d_gnt = 1; e_mem_we = d_we; e_mem_addr = d_addr; e_mem_wdata = d_wdata;
          end
          default: begin
            e_i_gnt = 1; e_mem_addr = i_addr[8:1];
          end
        endcase
        if (e_mem_we != 2'b00) begin
          if (e_mem_we[0]) ref_mem[e_mem_addr][31:0]  = e_mem_wdata[31:0];
          if (e_mem_we[1]) ref_mem[e_mem_addr][63:32] = e_mem_wdata[63:32];
          m_wait = 1;
        end else begin
          m_wait = MEM_LAT + 1; m_rv_in = MEM_LAT + 1; m_rv_who = who;
          m_rv_word = ref_mem[e_mem_addr]; m_rv_half = i_addr[0];
        end
        if (i_req) m_starve = (who == 3) ? 0 : ((m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX);
      end
      if (!i_req) m_starve = 0;
      e_busy = (m_wait != 0);
    end
  end

  logic cmp_on = 1'b0;
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("m_ld_gnt",   64'(ld_gnt),   64'(e_ld_gnt));
      chk("m_d_gnt",    64'(d_gnt),    64'(e_d_gnt));
      chk("m_i_gnt",    64'(i_gnt),    64'(e_i_gnt));
      chk("m_mem_en",   64'(mem_en),   64'(e_mem_en));
      chk("m_mem_we",   64'(mem_we),   64'(e_mem_we));
      chk("m_mem_addr", 64'(mem_addr), 64'(e_mem_addr));
      if (e_mem_we != 2'b00) chk("m_mem_wdata", mem_wdata, e_mem_wdata);
      chk("m_busy",     64'(busy),     64'(e_busy));
      chk("m_d_rvalid", 64'(d_rvalid), 64'(e_d_rv));
      chk("m_i_rvalid", 64'(i_rvalid), 64'(e_i_rv));
      chk("m_d_rdata",  d_rdata,       e_d_rdata);
      chk("m_i_rdata",  64'(i_rdata),  64'(e_i_rdata));
    end
  end

  function automatic logic [63:0] gnt_code();
    return ld_gnt ? 64'd1 : d_gnt ? 64'd2 : i_gnt ? 64'd3 : 64'd0;
  endfunction

  task automatic preload(input logic [7:0] a, input logic [63:0] v);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = v;
  endtask

  logic [63:0] exp4 [1:5];
  logic [63:0] exp5 [1:13];

  initial begin
    ld_req = 1; ld_addr = 9'h011; ld_wdata = 32'h1111_2222;
    d_req = 1; d_we = 2'b00; d_addr = 8'h03; d_wdata = 64'h0;
    i_req = 1; i_addr = 9'h004;
    #1 reset = 1'b0;
    cmp_on = 1'b1;

    // Reset held with all requests up; initialise the low memory words meanwhile.
    for (int a = 0; a < 32; a++) preload(8'(a), {$urandom, $urandom});
    @(negedge clk);
    pl_en = 1'b0;
    @(negedge clk);
    chk("t1_ld_gnt", 64'(ld_gnt), 64'd0);
    chk("t1_d_gnt", 64'(d_gnt), 64'd0);
    chk("t1_i_gnt", 64'(i_gnt), 64'd0);
    chk("t1_mem_en", 64'(mem_en), 64'd0);
    chk("t1_mem_we", 64'(mem_we), 64'd0);
    chk("t1_mem_addr", 64'(mem_addr), 64'd0);
    chk("t1_mem_wdata", mem_wdata, 64'd0);
    chk("t1_busy", 64'(busy), 64'd0);
    chk("t1_rvalid", 64'({d_rvalid, i_rvalid}), 64'd0);
    chk("t1_rdata", d_rdata | 64'(i_rdata), 64'd0);
    ld_req = 0; d_req = 0; i_req = 0;
    #2 reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("t1_idle_mem_en", 64'(mem_en), 64'd0);
    end

    // Loader write to the upper half of word 2.
    ld_req = 1; ld_addr = 9'h005; ld_wdata = 32'h7;
    @(negedge clk);
    chk("t2_ld_gnt", 64'(ld_gnt), 64'd1);
    chk("t2_mem_en", 64'(mem_en), 64'd1);
    chk("t2_mem_we", 64'(mem_we), 64'd2);
    chk("t2_mem_addr", 64'(mem_addr), 64'd2);
    chk("t2_mem_wdata", mem_wdata, 64'h00000007_00000007);
    ld_req = 0;
    repeat (2) @(negedge clk);

    // Data read of word 40.
    preload(8'd40, 64'd4950);
    @(negedge clk);
    pl_en = 0; d_req = 1; d_we = 2'b00; d_addr = 8'd40; d_wdata = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    chk("t3_d_gnt_c1", 64'(d_gnt), 64'd1);
    chk("t3_busy_c1", 64'(busy), 64'd1);
    d_req = 0;
    @(negedge clk);
    chk("t3_busy_c2", 64'(busy), 64'd1);
    @(negedge clk);
    chk("t3_busy_c3", 64'(busy), 64'd1);
    chk("t3_rvalid_c3", 64'(d_rvalid), 64'd0);
    @(negedge clk);
    chk("t3_rvalid_c4", 64'(d_rvalid), 64'd1);
    chk("t3_rdata_c4", d_rdata, 64'd4950);
    chk("t3_busy_c4", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);

    // Simultaneous loader, data write and fetch.
    exp4 = '{64'd1, 64'd0, 64'd2, 64'd0, 64'd3};
    ld_req = 1; ld_addr = 9'h020; ld_wdata = 32'hA5A5_0001;
    d_req = 1; d_we = 2'b11; d_addr = 8'd5; d_wdata = 64'h5555_6666_7777_8888;
    i_req = 1; i_addr = 9'h00B;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk($sformatf("t4_gnt_c%0d", c), gnt_code(), exp4[c]);
      if (ld_gnt) ld_req = 0;
      if (d_gnt) d_req = 0;
      if (i_gnt) i_req = 0;
    end
    repeat (3) @(negedge clk);
    chk("t4_i_rvalid_c8", 64'(i_rvalid), 64'd1);
    repeat (2) @(negedge clk);

    // Fetch starvation guard against back-to-back data writes.
    exp5 = '{64'd2, 64'd0, 64'd2, 64'd0, 64'd2, 64'd0, 64'd2, 64'd0, 64'd3, 64'd0, 64'd0, 64'd0, 64'd2};
    d_req = 1; d_we = 2'b01; d_addr = 8'd7; d_wdata = {$urandom, $urandom};
    i_req = 1; i_addr = 9'h010;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      chk($sformatf("t5_gnt_c%0d", c), gnt_code(), exp5[c]);
      if (d_gnt) begin
        d_we = 2'($urandom_range(1, 3)); d_addr = 8'($urandom_range(0, 31)); d_wdata = {$urandom, $urandom};
      end
      if (i_gnt) i_req = 0;
    end
    d_req = 0;
    repeat (3) @(negedge clk);

    // Reset during the read wait of a fetch, then a clean re-fetch.
    preload(8'h33, 64'hCAFEF00D_12345678);
    @(negedge clk);
    pl_en = 0; i_req = 1; i_addr = {8'h33, 1'b1};
    @(negedge clk);
    chk("t6_i_gnt", 64'(i_gnt), 64'd1);
    i_req = 0;
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("t6_busy_rst", 64'(busy), 64'd0);
    chk("t6_rvalid_rst", 64'(i_rvalid), 64'd0);
    @(posedge clk);
    #2 reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t6_no_rvalid", 64'(i_rvalid), 64'd0);
      chk("t6_idle", 64'(busy), 64'd0);
    end
    i_req = 1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("t6_regnt", 64'(i_gnt), 64'd1);
        i_req = 0;
      end
      if (c < 4) chk("t6_rvalid_early", 64'(i_rvalid), 64'd0);
      if (c == 4) begin
        chk("t6_rvalid", 64'(i_rvalid), 64'd1);
        chk("t6_rdata", 64'(i_rdata), 64'hCAFEF00D);
      end
    end

    // Randomized traffic, including requests dropped before grant and one reset pulse.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (ld_gnt || (ld_req && $urandom_range(0, 15) == 0)) ld_req = 0;
      if (d_gnt || (d_req && $urandom_range(0, 15) == 0)) d_req = 0;
      if (i_gnt || (i_req && $urandom_range(0, 15) == 0)) i_req = 0;
      if (!ld_req && $urandom_range(0, 5) == 0) begin
        ld_req = 1; ld_addr = 9'($urandom_range(0, 63)); ld_wdata = $urandom;
      end
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1; d_we = 2'($urandom_range(0, 3)); d_addr = 8'($urandom_range(0, 31));
        d_wdata = {$urandom, $urandom};
      end
      if (!i_req && $urandom_range(0, 2) == 0) begin
        i_req = 1; i_addr = 9'($urandom_range(0, 63));
      end
      if (n == 1500) begin
        #2 reset = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
      end
    end
    ld_req = 0; d_req = 0; i_req = 0;
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
